// File: rtl/dac_wave_pkg.sv
// Shared types and default sizing for the DAC waveform playback engine.
package dac_wave_pkg;

  // Per-channel playback state; also exported on the debug state bus.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wave_state_e;

  localparam int STATE_W    = 2;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 14;
  localparam int DEF_DIV_W  = 16;

endpackage

// File: rtl/dac_wave_chan.sv
// Single playback channel: IDLE/RUN/DONE FSM, rate divider, address counter
// and the two-stage read pipeline that returns RAM data to the DAC register.
//
// Read interface: mem_rd_o is a one-cycle strobe qualifying mem_addr_o; the
// synchronous RAM returns the word on mem_data_i in the following cycle with
// no backpressure, so every strobe is tracked by pend_q exactly one cycle
// later and consumed (or dropped on disable/reset) on the next edge.
module dac_wave_chan
  import dac_wave_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                DIV_W     = DEF_DIV_W,
  parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(1 << (DATA_W - 1))
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                oneshot_i,
  input  logic [ADDR_W-1:0]   len_i,
  input  logic [DIV_W-1:0]    div_i,
  output logic                mem_rd_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic [DATA_W-1:0]   mem_data_i,
  output logic [DATA_W-1:0]   dac_o,
  output logic                dac_vld_o,
  output logic                done_o,
  output logic [STATE_W-1:0]  state_o
);

  wave_state_e       state_q,     state_d;
  logic [ADDR_W-1:0] len_q,       len_d;
  logic [DIV_W-1:0]  div_q,       div_d;
  logic              oneshot_q,   oneshot_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DIV_W-1:0]  cnt_q,       cnt_d;
  logic              rd_end_q,    rd_end_d;
  logic              rd_q,        rd_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic              rd_last_q,   rd_last_d;
  logic              pend_q,      pend_d;
  logic              pend_last_q, pend_last_d;
  logic [DATA_W-1:0] dac_q,       dac_d;
  logic              vld_q,       vld_d;
  logic              done_q,      done_d;

  logic              at_last;
  logic              div_tick;

  assign at_last  = (addr_q == len_q);
  assign div_tick = (cnt_q == '0);

  // Next-state, counter and read-pipeline logic for one channel.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    div_d       = div_q;
    oneshot_d   = oneshot_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rd_end_d    = rd_end_q;
    rd_d        = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_last_d   = 1'b0;
    pend_d      = rd_q;
    pend_last_d = rd_last_q;
    dac_d       = dac_q;
    vld_d       = 1'b0;
    done_d      = done_q;

    case (state_q)
      IDLE: begin
        dac_d  = IDLE_CODE;
        done_d = 1'b0;
        if (en_i) begin
          // Configuration is captured here and frozen for the whole run.
          len_d     = len_i;
          div_d     = div_i;
          oneshot_d = oneshot_i;
          addr_d    = '0;
          cnt_d     = '0;
          rd_end_d  = 1'b0;
          state_d   = RUN;
        end
      end

      RUN: begin
        cnt_d = (cnt_q == div_q) ? '0 : cnt_q + DIV_W'(1);

        if (div_tick && !rd_end_q) begin
          rd_d      = 1'b1;
          rd_addr_d = addr_q;
          rd_last_d = at_last;
          if (at_last) begin
            addr_d = '0;
            // One-shot stops fetching after the final address.
            if (oneshot_q) begin
              rd_end_d = 1'b1;
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end

        if (pend_q) begin
          dac_d = mem_data_i;
          vld_d = 1'b1;
          // done rises together with the final sample's valid pulse.
          if (pend_last_q && oneshot_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        done_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        dac_d   = IDLE_CODE;
        done_d  = 1'b0;
      end
    endcase

    // Disable wins over everything, including a read already in flight.
    if (!en_i) begin
      state_d     = IDLE;
      rd_d        = 1'b0;
      rd_last_d   = 1'b0;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      vld_d       = 1'b0;
      dac_d       = IDLE_CODE;
      done_d      = 1'b0;
    end
  end

  // State, counters and registered outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      div_q       <= '0;
      oneshot_q   <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      rd_end_q    <= 1'b0;
      rd_q        <= 1'b0;
      rd_addr_q   <= '0;
      rd_last_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      dac_q       <= IDLE_CODE;
      vld_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      div_q       <= div_d;
      oneshot_q   <= oneshot_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rd_end_q    <= rd_end_d;
      rd_q        <= rd_d;
      rd_addr_q   <= rd_addr_d;
      rd_last_q   <= rd_last_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      dac_q       <= dac_d;
      vld_q       <= vld_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd_o   = rd_q;
  assign mem_addr_o = rd_addr_q;
  assign dac_o      = dac_q;
  assign dac_vld_o  = vld_q;
  assign done_o     = done_q;
  assign state_o    = state_q;

endmodule

// File: rtl/dac_wave_player.sv
// Multi-channel waveform player: one independent dac_wave_chan per channel,
// with flattened per-channel buses (channel k at slice [k*W +: W]).
module dac_wave_player
  import dac_wave_pkg::*;
#(
  parameter int                NUM_CH    = DEF_NUM_CH,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                DIV_W     = DEF_DIV_W,
  parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(1 << (DATA_W - 1))
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_CH-1:0]           en_i,
  input  logic [NUM_CH-1:0]           oneshot_i,
  input  logic [NUM_CH*ADDR_W-1:0]    len_i,
  input  logic [NUM_CH*DIV_W-1:0]     div_i,
  output logic [NUM_CH-1:0]           mem_rd_o,
  output logic [NUM_CH*ADDR_W-1:0]    mem_addr_o,
  input  logic [NUM_CH*DATA_W-1:0]    mem_data_i,
  output logic [NUM_CH*DATA_W-1:0]    dac_o,
  output logic [NUM_CH-1:0]           dac_vld_o,
  output logic [NUM_CH-1:0]           done_o,
  output logic [NUM_CH*STATE_W-1:0]   dbg_state_o
);

  // One channel instance per slice; nothing is shared between channels.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dac_wave_chan #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .DIV_W     (DIV_W),
      .IDLE_CODE (IDLE_CODE)
    ) u_chan (
      .clk        (sys_clk),
      .rst        (sys_rst),
      .en_i       (en_i[g]),
      .oneshot_i  (oneshot_i[g]),
      .len_i      (len_i[g*ADDR_W +: ADDR_W]),
      .div_i      (div_i[g*DIV_W +: DIV_W]),
      .mem_rd_o   (mem_rd_o[g]),
      .mem_addr_o (mem_addr_o[g*ADDR_W +: ADDR_W]),
      .mem_data_i (mem_data_i[g*DATA_W +: DATA_W]),
      .dac_o      (dac_o[g*DATA_W +: DATA_W]),
      .dac_vld_o  (dac_vld_o[g]),
      .done_o     (done_o[g]),
      .state_o    (dbg_state_o[g*STATE_W +: STATE_W])
    );
  end

endmodule

// File: tb/tb_dac_wave_player.sv
// Directed bench for dac_wave_player: reset/idle, loop, one-shot with divider,
// channel independence with config latching, and abort by disable or reset.
module tb_dac_wave_player;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 14;
  localparam int DIV_W  = 16;
  localparam int ST_W   = 2;
  localparam logic [DATA_W-1:0] IDLE_V = 14'h2000;

  logic                      sys_clk;
  logic                      sys_rst;
  logic [NUM_CH-1:0]         en_i;
  logic [NUM_CH-1:0]         oneshot_i;
  logic [NUM_CH*ADDR_W-1:0]  len_i;
  logic [NUM_CH*DIV_W-1:0]   div_i;
  logic [NUM_CH-1:0]         mem_rd_o;
  logic [NUM_CH*ADDR_W-1:0]  mem_addr_o;
  logic [NUM_CH*DATA_W-1:0]  mem_data_i;
  logic [NUM_CH*DATA_W-1:0]  dac_o;
  logic [NUM_CH-1:0]         dac_vld_o;
  logic [NUM_CH-1:0]         done_o;
  logic [NUM_CH*ST_W-1:0]    dbg_state_o;

  dac_wave_player #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .en_i        (en_i),
    .oneshot_i   (oneshot_i),
    .len_i       (len_i),
    .div_i       (div_i),
    .mem_rd_o    (mem_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .dac_o       (dac_o),
    .dac_vld_o   (dac_vld_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc_cnt = 0;
  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  // Synchronous-read RAM model: ch0 holds mem[i]=i, ch1 holds 0x1000|i.
  logic [DATA_W-1:0] ram_q [NUM_CH];
  always @(posedge sys_clk) begin
    if (mem_rd_o[0]) ram_q[0] <= DATA_W'(mem_addr_o[0 +: ADDR_W]);
    if (mem_rd_o[1]) ram_q[1] <= 14'h1000 | DATA_W'(mem_addr_o[ADDR_W +: ADDR_W]);
  end
  assign mem_data_i = {ram_q[1], ram_q[0]};

  // ---------------- check bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int ch, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s ch%0d cyc=%0d: got %0h expected %0h", name, ch, cyc_cnt, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] dac_of(input int ch);
    return dac_o[ch*DATA_W +: DATA_W];
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input int ch);
    return mem_addr_o[ch*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [ST_W-1:0] st_of(input int ch);
    return dbg_state_o[ch*ST_W +: ST_W];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic set_ch(input int ch, input logic en, input logic os,
                        input logic [ADDR_W-1:0] len, input logic [DIV_W-1:0] div);
    en_i[ch]                    = en;
    oneshot_i[ch]               = os;
    len_i[ch*ADDR_W +: ADDR_W]  = len;
    div_i[ch*DIV_W +: DIV_W]    = div;
  endtask

  task automatic check_quiet(input string tag, input int ch);
    chk({tag, " dac"},   ch, dac_of(ch),    IDLE_V);
    chk({tag, " rd"},    ch, mem_rd_o[ch],  1'b0);
    chk({tag, " vld"},   ch, dac_vld_o[ch], 1'b0);
    chk({tag, " done"},  ch, done_o[ch],    1'b0);
    chk({tag, " state"}, ch, st_of(ch),     2'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic              vld;
    logic [DATA_W-1:0] dac;
    logic              done;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rd, input logic [ADDR_W-1:0] addr, input logic vld,
                         input logic [DATA_W-1:0] dac, input logic done);
    vec_t v;
    v.rd = rd; v.addr = addr; v.vld = vld; v.dac = dac; v.done = done;
    vecs.push_back(v);
  endtask

  // Row i is checked in cycle T+i; caller is positioned at cycle T.
  task automatic run_vecs(input string tag, input int ch);
    foreach (vecs[i]) begin
      chk({tag, " rd"},   ch, mem_rd_o[ch],  vecs[i].rd);
      if (vecs[i].rd) chk({tag, " addr"}, ch, addr_of(ch), vecs[i].addr);
      chk({tag, " vld"},  ch, dac_vld_o[ch], vecs[i].vld);
      chk({tag, " dac"},  ch, dac_of(ch),    vecs[i].dac);
      chk({tag, " done"}, ch, done_o[ch],    vecs[i].done);
      step();
    end
    vecs.delete();
  endtask

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];      // ch0 sample sequence
  logic [DATA_W-1:0] exp_d1_q[$];   // ch1 sample values
  int                exp_t1_q[$];   // ch1 pulse offsets from t0
  bit                mon_en = 1'b0;
  int                t0 = 0;

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (dac_vld_o[0]) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ch0 extra vld cyc=%0d: got dac %0h expected no pulse", cyc_cnt, dac_of(0));
        end else begin
          chk("sb ch0 seq", 0, dac_of(0), exp_q.pop_front());
        end
      end
      if (dac_vld_o[1]) begin
        if (exp_d1_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ch1 extra vld cyc=%0d: got dac %0h expected no pulse", cyc_cnt, dac_of(1));
        end else begin
          chk("sb ch1 time", 1, cyc_cnt - t0, exp_t1_q.pop_front());
          chk("sb ch1 data", 1, dac_of(1), exp_d1_q.pop_front());
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    sys_rst = 1'b1; en_i = '0; oneshot_i = '0; len_i = '0; div_i = '0;
    @(negedge sys_clk);
    step(); step();

    // Reset values while reset is still asserted.
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check_quiet("rst", ch);
      chk("rst addr", ch, addr_of(ch), '0);
    end
    sys_rst = 1'b0;

    // Idle for 20 cycles with everything disabled.
    for (int k = 0; k < 20; k++) begin
      step();
      for (int ch = 0; ch < NUM_CH; ch++) check_quiet("idle", ch);
    end

    // Loop mode, len=3, div=0: samples every cycle from T+3, wrapping 3->0.
    set_ch(0, 1'b1, 1'b0, 11'd3, 16'd0);
    step();
    add_vec(0, 0, 0, IDLE_V, 0);
    add_vec(1, 0, 0, IDLE_V, 0);
    add_vec(1, 1, 0, IDLE_V, 0);
    add_vec(1, 2, 1, 14'd0, 0);
    add_vec(1, 3, 1, 14'd1, 0);
    add_vec(1, 0, 1, 14'd2, 0);
    add_vec(1, 1, 1, 14'd3, 0);
    add_vec(1, 2, 1, 14'd0, 0);
    add_vec(1, 3, 1, 14'd1, 0);
    run_vecs("loop", 0);
    set_ch(0, 1'b0, 1'b0, 11'd3, 16'd0);
    step();
    check_quiet("loop off", 0);

    // One-shot, len=2, div=4: pulses at T+3, T+8, T+13; done with the last.
    set_ch(0, 1'b1, 1'b1, 11'd2, 16'd4);
    step();
    add_vec(0, 0, 0, IDLE_V, 0);  // T
    add_vec(1, 0, 0, IDLE_V, 0);  // T+1
    add_vec(0, 0, 0, IDLE_V, 0);
    add_vec(0, 0, 1, 14'd0, 0);   // T+3
    add_vec(0, 0, 0, 14'd0, 0);
    add_vec(0, 0, 0, 14'd0, 0);
    add_vec(1, 1, 0, 14'd0, 0);   // T+6
    add_vec(0, 0, 0, 14'd0, 0);
    add_vec(0, 0, 1, 14'd1, 0);   // T+8
    add_vec(0, 0, 0, 14'd1, 0);
    add_vec(0, 0, 0, 14'd1, 0);
    add_vec(1, 2, 0, 14'd1, 0);   // T+11
    add_vec(0, 0, 0, 14'd1, 0);
    add_vec(0, 0, 1, 14'd2, 1);   // T+13
    add_vec(0, 0, 0, 14'd2, 1);
    add_vec(0, 0, 0, 14'd2, 1);
    run_vecs("oneshot", 0);
    chk("oneshot state", 0, st_of(0), 2'd2);
    set_ch(0, 1'b0, 1'b1, 11'd2, 16'd4);
    step();
    check_quiet("oneshot off", 0);

    // Independence: ch0 loop len=3 div=0, ch1 one-shot len=1 div=9.
    for (int i = 0; i < 28; i++) exp_q.push_back(DATA_W'(i % 4));
    exp_t1_q.push_back(3);  exp_d1_q.push_back(14'h1000);
    exp_t1_q.push_back(13); exp_d1_q.push_back(14'h1001);
    set_ch(0, 1'b1, 1'b0, 11'd3, 16'd0);
    set_ch(1, 1'b1, 1'b1, 11'd1, 16'd9);
    t0 = cyc_cnt + 1;
    mon_en = 1'b1;
    step();
    for (int k = 0; k < 30; k++) begin
      if (k == 10) begin
        // Mid-run config changes must not reach either running channel.
        len_i[0 +: ADDR_W]       = 11'd1;
        len_i[ADDR_W +: ADDR_W]  = 11'd5;
        div_i[DIV_W +: DIV_W]    = 16'd0;
      end
      if (k == 12) chk("indep ch1 done pre", 1, done_o[1], 1'b0);
      if (k == 13) chk("indep ch1 done", 1, done_o[1], 1'b1);
      step();
    end
    chk("indep ch1 hold", 1, dac_of(1), 14'h1001);
    chk("indep ch1 done hold", 1, done_o[1], 1'b1);
    set_ch(0, 1'b0, 1'b0, 11'd1, 16'd0);
    set_ch(1, 1'b0, 1'b1, 11'd5, 16'd0);
    step();
    mon_en = 1'b0;
    chk("indep ch0 left", 0, exp_q.size(), 0);
    chk("indep ch1 left", 1, exp_d1_q.size(), 0);

    // Re-enable ch0: the new len=1 now takes effect.
    for (int i = 0; i < 6; i++) exp_q.push_back(DATA_W'(i % 2));
    mon_en = 1'b1;
    set_ch(0, 1'b1, 1'b0, 11'd1, 16'd0);
    step();
    for (int k = 0; k < 8; k++) step();
    set_ch(0, 1'b0, 1'b0, 11'd1, 16'd0);
    step();
    mon_en = 1'b0;
    chk("relatch ch0 left", 0, exp_q.size(), 0);
    check_quiet("relatch off", 0);

    // Abort by disable the cycle after the read strobe.
    set_ch(0, 1'b1, 1'b0, 11'd3, 16'd4);
    step();
    step();
    chk("abort en rd", 0, mem_rd_o[0], 1'b1);
    step();
    en_i[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_quiet("abort en", 0);
    end

    // Abort by synchronous reset at the same point.
    en_i[0] = 1'b1;
    step();
    step();
    chk("abort rst rd", 0, mem_rd_o[0], 1'b1);
    step();
    sys_rst = 1'b1;
    step();
    check_quiet("abort rst", 0);
    chk("abort rst addr", 0, addr_of(0), '0);
    sys_rst = 1'b0;
    en_i[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_quiet("post rst", 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_wave_player.md
# dac_wave_player

Multi-channel waveform playback engine, next generation of the DAC memory controller. It streams samples from per-channel synchronous-read sample RAMs to DAC channels. Each channel has its own length, rate divider and loop/one-shot mode, and the channel count is a parameter. It sits between the CSR-loaded DAC sample RAMs (read port) and the `dac` IP data inputs, all in the `sys_clk` domain.

## Interface
Parameters:
- `NUM_CH`, 2: number of independent playback channels.
- `ADDR_W`, 11: sample RAM address width per channel.
- `DATA_W`, 14: DAC sample width.
- `DIV_W`, 16: rate-divider width.
- `IDLE_CODE`, `DATA_W'(1<<(DATA_W-1))`: midscale value driven when a channel is idle.

Ports (all vectors are flattened; channel k occupies slice `[k*W +: W]`):
- `sys_clk` in 1: system clock. One clock; everything is synchronous to it.
- `sys_rst` in 1: reset, synchronous, active-high.
- `en_i` in NUM_CH: channel enable (level).
- `oneshot_i` in NUM_CH: 1 = play once then hold; 0 = loop.
- `len_i` in NUM_CH*ADDR_W: last sample address. Samples played = len+1.
- `div_i` in NUM_CH*DIV_W: one sample every div+1 cycles.
- `mem_rd_o` out NUM_CH: RAM read strobe.
- `mem_addr_o` out NUM_CH*ADDR_W: RAM read address. Data is valid the cycle after the strobe.
- `mem_data_i` in NUM_CH*DATA_W: RAM read data.
- `dac_o` out NUM_CH*DATA_W: sample to the DAC, registered.
- `dac_vld_o` out NUM_CH: 1-cycle pulse when `dac_o` updates with a new sample.
- `done_o` out NUM_CH: one-shot playback complete (level).

## Operation
- Each channel runs its own FSM with states IDLE, RUN and DONE. Channels are fully independent.
- IDLE:
  - `dac_o`=IDLE_CODE; `mem_rd_o`=0; `done_o`=0.
  - When `en_i`=1: latch `len_i` and `div_i`, clear the address and divider counter, go to RUN.
- RUN:
  - When the divider counter = 0, assert `mem_rd_o` with the current address.
  - The counter counts 0..div_latched and then wraps to 0.
  - After each read, address +1. At address == len_latched:
    - Loop mode: the address wraps to 0 and the channel stays in RUN.
    - One-shot mode: issue no more reads; go to DONE once the last sample reaches `dac_o`.
- DONE: hold the last sample on `dac_o`, `done_o`=1, no reads. Leave only when `en_i`=0, which returns the channel to IDLE.
- `en_i`=0 in any state: go to IDLE next cycle. Any in-flight read is discarded (no `dac_vld_o`), and `dac_o`=IDLE_CODE.
- `len_i`, `div_i` and `oneshot_i` changes during RUN are ignored. They take effect on the next IDLE→RUN transition. `oneshot_i` is latched at that transition.
- len=0: a single sample; loop mode re-reads address 0 every div+1 cycles.
- Width rules:
  - Address and divider counters are unsigned and wrap naturally.
  - `mem_data_i` passes through unmodified; no arithmetic is applied.

## Timing
- Reset values, every channel: IDLE; `dac_o`=IDLE_CODE; `mem_rd_o`=0; `mem_addr_o`=0; `dac_vld_o`=0; `done_o`=0.
- Reset mid-operation behaves identically to the reset case above. No pending read survives.
- Start latency (`en_i` sampled high at edge T):
  - T+1: `mem_rd_o`=1, addr 0.
  - T+2: RAM data valid.
  - T+3: `dac_o`=mem[0] with `dac_vld_o`=1.
- Steady state: reads and `dac_vld_o` pulses are exactly div+1 cycles apart. div=0 gives one sample per cycle with no gaps, including across the loop wrap.
- One-shot: `done_o` rises in the same cycle as the `dac_vld_o` of sample len.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `dac_wave_pkg`:
  - channel state enum `wave_state_e` {IDLE, RUN, DONE};
  - default parameter constants.
- Sub-module `dac_wave_chan`: single-channel FSM, counters and read pipeline.
- `dac_wave_player` is a generate loop over NUM_CH plus slice mapping. No logic is shared between channels.

## Test plan
- Reset and idle: reset asserted, then held idle 20 cycles → every `dac_o`=0x2000; `mem_rd_o`, `dac_vld_o` and `done_o` stay 0.
- Loop, NUM_CH=2: RAM holds mem[i]=i, len=3, div=0, ch0 enabled at T → `dac_o` 0,1,2,3,0,1… from T+3, with `dac_vld_o` on every cycle.
- One-shot with divider: len=2, div=4 → pulses at T+3, T+8, T+13. `done_o`=1 at T+13 and the held value is 2. `en_i`=0 → next cycle `dac_o`=0x2000 and `done_o`=0.
- Independence and latching: ch0 loop with div=0, ch1 one-shot with div=9. Change len_i[ch0] mid-run → ch0 sequence unaffected until re-enable. ch1 timing is unaffected by ch0.
- Abort mid-read: drop `en_i` the cycle after `mem_rd_o` → no `dac_vld_o` follows, and `dac_o` returns to IDLE_CODE. Repeat with `sys_rst` instead of `en_i` → same result.
